// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALUOp, PCSource and ALUSrcB codes, plus the decoded opcode class.
package multi_cycle_control_pkg;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_EXEC_R    = 4'd3;
   localparam logic [3:0] S_R_WB      = 4'd4;
   localparam logic [3:0] S_EXEC_I    = 4'd5;
   localparam logic [3:0] S_I_WB      = 4'd6;
   localparam logic [3:0] S_MEM_ADDR  = 4'd7;
   localparam logic [3:0] S_MEM_READ  = 4'd8;
   localparam logic [3:0] S_MEM_WB    = 4'd9;
   localparam logic [3:0] S_MEM_WRITE = 4'd10;
   localparam logic [3:0] S_BRANCH    = 4'd11;
   localparam logic [3:0] S_JUMP      = 4'd12;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   typedef struct packed {
      logic r;
      logic addi;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic illegal;
   } op_class_t;

endpackage

// File: rtl/multi_cycle_control_opcode_decode.sv
// Combinational opcode classifier: one-hot instruction class from the opcode.
module mc_opcode_decode
   import multi_cycle_control_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] op_i,
   output op_class_t       class_o
);

   // One-hot match against the supported opcodes; anything else is illegal.
   always_comb begin
      class_o         = '0;
      class_o.r       = (op_i == OP_W'(OP_R));
      class_o.addi    = (op_i == OP_W'(OP_ADDI));
      class_o.lw      = (op_i == OP_W'(OP_LW));
      class_o.sw      = (op_i == OP_W'(OP_SW));
      class_o.beq     = (op_i == OP_W'(OP_BEQ));
      class_o.j       = (op_i == OP_W'(OP_J));
      class_o.illegal = ~(class_o.r | class_o.addi | class_o.lw |
                          class_o.sw | class_o.beq | class_o.j);
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit.
// state     | meaning
// IDLE      | after reset, all outputs 0
// FETCH     | read instruction, PC+4; waits for Mem_ready_i
// DECODE    | branch target precompute, dispatch on opcode
// EXEC_R    | R-type ALU operation (funct)
// R_WB      | R-type result to rd, retire
// EXEC_I    | addi ALU operation
// I_WB      | addi result to rt, retire
// MEM_ADDR  | lw/sw address calculation
// MEM_READ  | data read, waits for Mem_ready_i
// MEM_WB    | MDR to rt, retire
// MEM_WRITE | data write, waits for Mem_ready_i, retires on ready
// BRANCH    | beq compare, conditional PC load, retire
// JUMP      | jump target to PC, retire
module multi_cycle_control
   import multi_cycle_control_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 2,
   parameter int CNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [OP_W-1:0]    Op_i,
   input  logic               Mem_ready_i,
   output logic               PCWrite_o,
   output logic               PCWriteCond_o,
   output logic               IorD_o,
   output logic               MemRead_o,
   output logic               MemWrite_o,
   output logic               IRWrite_o,
   output logic               MemtoReg_o,
   output logic [1:0]         PCSource_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic               ALUSrcA_o,
   output logic [1:0]         ALUSrcB_o,
   output logic               RegWrite_o,
   output logic               RegDst_o,
   output logic               Illegal_o,
   output logic               Retire_o,
   output logic [CNT_W-1:0]   Retired_o
);

   logic [3:0]       state_q, state_d;
   logic             is_lw_q, is_lw_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [1:0]       aluop;
   op_class_t        op_class;

   mc_opcode_decode #(.OP_W(OP_W)) u_opdec (
      .op_i    (Op_i),
      .class_o (op_class)
   );

   // Next-state logic; lw/sw choice is captured in DECODE since Op_i is only trusted there.
   always_comb begin
      state_d = state_q;
      is_lw_d = is_lw_q;
      case (state_q)
         S_IDLE:      state_d = S_FETCH;
         S_FETCH:     if (Mem_ready_i) state_d = S_DECODE;
         S_DECODE: begin
            if (op_class.r)                    state_d = S_EXEC_R;
            else if (op_class.addi)            state_d = S_EXEC_I;
            else if (op_class.lw | op_class.sw) begin
               state_d = S_MEM_ADDR;
               is_lw_d = op_class.lw;
            end
            else if (op_class.beq)             state_d = S_BRANCH;
            else if (op_class.j)               state_d = S_JUMP;
            else                               state_d = S_FETCH;
         end
         S_EXEC_R:    state_d = S_R_WB;
         S_EXEC_I:    state_d = S_I_WB;
         S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (Mem_ready_i) state_d = S_MEM_WB;
         S_MEM_WRITE: if (Mem_ready_i) state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
   end

   // Output decode from state; FETCH, MEM_WRITE and DECODE pulses are qualified by inputs.
   always_comb begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 1'b0;
      PCSource_o    = PCSRC_ALU;
      aluop         = ALUOP_ADD;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = SRCB_RT;
      RegWrite_o    = 1'b0;
      RegDst_o      = 1'b0;
      Illegal_o     = 1'b0;
      Retire_o      = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead_o = 1'b1;
            ALUSrcB_o = SRCB_FOUR;
            IRWrite_o = Mem_ready_i;
            PCWrite_o = Mem_ready_i;
         end
         S_DECODE: begin
            ALUSrcB_o = SRCB_IMM_SH;
            Illegal_o = op_class.illegal;
         end
         S_EXEC_R: begin
            ALUSrcA_o = 1'b1;
            aluop     = ALUOP_FUNCT;
         end
         S_R_WB: begin
            RegDst_o   = 1'b1;
            RegWrite_o = 1'b1;
            Retire_o   = 1'b1;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = SRCB_IMM;
         end
         S_I_WB: begin
            RegWrite_o = 1'b1;
            Retire_o   = 1'b1;
         end
         S_MEM_READ: begin
            IorD_o    = 1'b1;
            MemRead_o = 1'b1;
         end
         S_MEM_WB: begin
            MemtoReg_o = 1'b1;
            RegWrite_o = 1'b1;
            Retire_o   = 1'b1;
         end
         S_MEM_WRITE: begin
            IorD_o     = 1'b1;
            MemWrite_o = 1'b1;
            Retire_o   = Mem_ready_i;
         end
         S_BRANCH: begin
            ALUSrcA_o     = 1'b1;
            aluop         = ALUOP_SUB;
            PCWriteCond_o = 1'b1;
            PCSource_o    = PCSRC_ALUOUT;
            Retire_o      = 1'b1;
         end
         S_JUMP: begin
            PCWrite_o  = 1'b1;
            PCSource_o = PCSRC_JUMP;
            Retire_o   = 1'b1;
         end
         default: ;
      endcase
   end

   assign ALUOp_o = ALUOP_W'(aluop);

   // Retired count advances on the edge after each retire pulse; wraps silently.
   always_comb begin
      retired_d = retired_q;
      if (Retire_o) retired_d = retired_q + CNT_W'(1);
   end

   assign Retired_o = retired_q;

   // State, lw/sw flag and counter registers with async active-low reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         is_lw_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         is_lw_q   <= is_lw_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle control vectors for each
// instruction class, stalls, illegal opcode, counter wrap (CNT_W=4 copy) and
// asynchronous reset mid-write.
module tb_multi_cycle_control;
   import multi_cycle_control_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [5:0] op;
   logic       mr;

   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
   logic [1:0]  PCSource, ALUOp, ALUSrcB;
   logic        ALUSrcA, RegWrite, RegDst, Illegal, Retire;
   logic [31:0] Retired;

   logic        PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4, IRWrite4, MemtoReg4;
   logic [1:0]  PCSource4, ALUOp4, ALUSrcB4;
   logic        ALUSrcA4, RegWrite4, RegDst4, Illegal4, Retire4;
   logic [3:0]  Retired4;

   multi_cycle_control dut (
      .clk_i(clk), .rst_n_i(rst_n), .Op_i(op), .Mem_ready_i(mr),
      .PCWrite_o(PCWrite), .PCWriteCond_o(PCWriteCond), .IorD_o(IorD),
      .MemRead_o(MemRead), .MemWrite_o(MemWrite), .IRWrite_o(IRWrite),
      .MemtoReg_o(MemtoReg), .PCSource_o(PCSource), .ALUOp_o(ALUOp),
      .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .RegWrite_o(RegWrite),
      .RegDst_o(RegDst), .Illegal_o(Illegal), .Retire_o(Retire),
      .Retired_o(Retired)
   );

   multi_cycle_control #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n), .Op_i(op), .Mem_ready_i(mr),
      .PCWrite_o(PCWrite4), .PCWriteCond_o(PCWriteCond4), .IorD_o(IorD4),
      .MemRead_o(MemRead4), .MemWrite_o(MemWrite4), .IRWrite_o(IRWrite4),
      .MemtoReg_o(MemtoReg4), .PCSource_o(PCSource4), .ALUOp_o(ALUOp4),
      .ALUSrcA_o(ALUSrcA4), .ALUSrcB_o(ALUSrcB4), .RegWrite_o(RegWrite4),
      .RegDst_o(RegDst4), .Illegal_o(Illegal4), .Retire_o(Retire4),
      .Retired_o(Retired4)
   );

   // {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcs[1:0], aluop[1:0], srca, srcb[1:0], rw, rd, ill, ret}
   logic [17:0] ctrl;
   assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, Illegal, Retire};

   int n_cmp = 0;
   int n_bad = 0;
   int exp_ret = 0;

   logic [17:0] V_FS, V_FR, V_DEC, V_DEC_ILL, V_EXR, V_RWB, V_EXI, V_IWB;
   logic [17:0] V_MA, V_MRD, V_MWB, V_MWR, V_MWR_RDY, V_BR, V_JMP;

   function automatic logic [17:0] v(input logic pcw, pcwc, iord, mrd, mwr, irw, m2r,
                                     input logic [1:0] pcs, aop, input logic srca,
                                     input logic [1:0] srcb, input logic rw, rd, ill, ret);
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcs, aop, srca, srcb, rw, rd, ill, ret};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [17:0] e);
      @(negedge clk);
      chk(tag, {14'b0, ctrl}, {14'b0, e});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ret(input string tag);
      chk({tag, "_cnt"}, Retired, 32'(exp_ret));
      chk({tag, "_cnt4"}, {28'b0, Retired4}, 32'(exp_ret % 16));
   endtask

   initial begin
      //                pcw pcwc iord mrd mwr irw m2r pcs   aop   sa srcb  rw rd il rt
      V_FS      = v(0,  0,   0,   1,  0,  0,  0,  2'd0, 2'd0, 0, 2'd1, 0, 0, 0, 0);
      V_FR      = v(1,  0,   0,   1,  0,  1,  0,  2'd0, 2'd0, 0, 2'd1, 0, 0, 0, 0);
      V_DEC     = v(0,  0,   0,   0,  0,  0,  0,  2'd0, 2'd0, 0, 2'd3, 0, 0, 0, 0);
      V_DEC_ILL = v(0,  0,   0,   0,  0,  0,  0,  2'd0, 2'd0, 0, 2'd3, 0, 0, 1, 0);
      V_EXR     = v(0,  0,   0,   0,  0,  0,  0,  2'd0, 2'd2, 1, 2'd0, 0, 0, 0, 0);
      V_RWB     = v(0,  0,   0,   0,  0,  0,  0,  2'd0, 2'd0, 0, 2'd0, 1, 1, 0, 1);
      V_EXI     = v(0,  0,   0,   0,  0,  0,  0,  2'd0, 2'd0, 1, 2'd2, 0, 0, 0, 0);
      V_IWB     = v(0,  0,   0,   0,  0,  0,  0,  2'd0, 2'd0, 0, 2'd0, 1, 0, 0, 1);
      V_MA      = v(0,  0,   0,   0,  0,  0,  0,  2'd0, 2'd0, 1, 2'd2, 0, 0, 0, 0);
      V_MRD     = v(0,  0,   1,   1,  0,  0,  0,  2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0);
      V_MWB     = v(0,  0,   0,   0,  0,  0,  1,  2'd0, 2'd0, 0, 2'd0, 1, 0, 0, 1);
      V_MWR     = v(0,  0,   1,   0,  1,  0,  0,  2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0);
      V_MWR_RDY = v(0,  0,   1,   0,  1,  0,  0,  2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 1);
      V_BR      = v(0,  1,   0,   0,  0,  0,  0,  2'd1, 2'd1, 1, 2'd0, 0, 0, 0, 1);
      V_JMP     = v(1,  0,   0,   0,  0,  0,  0,  2'd2, 2'd0, 0, 2'd0, 0, 0, 0, 1);

      rst_n = 1'b0;
      op    = OP_R;
      mr    = 1'b1;
      #2;
      chk("rst_ctrl", {14'b0, ctrl}, 32'h0);
      chk_ret("rst");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      cyc("idle", 18'h0);

      // R-type, no stalls
      op = OP_R; mr = 1'b1;
      cyc("r_fetch", V_FR); cyc("r_dec", V_DEC); cyc("r_exec", V_EXR); cyc("r_wb", V_RWB);
      exp_ret = 1; chk_ret("r");

      // lw, two stall cycles in MEM_READ; Op_i changed after DECODE must be ignored
      op = OP_LW; mr = 1'b1;
      cyc("lw_fetch", V_FR); cyc("lw_dec", V_DEC);
      op = OP_J;
      cyc("lw_addr", V_MA);
      mr = 1'b0; cyc("lw_rd0", V_MRD); cyc("lw_rd1", V_MRD);
      mr = 1'b1; cyc("lw_rd2", V_MRD);
      mr = 1'b0; cyc("lw_wb", V_MWB);
      exp_ret = 2; chk_ret("lw");

      // addi with one FETCH stall cycle
      op = OP_ADDI; mr = 1'b0;
      cyc("ad_fstall", V_FS);
      mr = 1'b1;
      cyc("ad_fetch", V_FR); cyc("ad_dec", V_DEC); cyc("ad_exec", V_EXI); cyc("ad_wb", V_IWB);
      exp_ret = 3; chk_ret("addi");

      // sw with one MEM_WRITE stall cycle
      op = OP_SW; mr = 1'b1;
      cyc("sw_fetch", V_FR); cyc("sw_dec", V_DEC); cyc("sw_addr", V_MA);
      mr = 1'b0; cyc("sw_wr0", V_MWR);
      chk_ret("sw_stall");
      mr = 1'b1; cyc("sw_wr1", V_MWR_RDY);
      exp_ret = 4; chk_ret("sw");

      // beq then j, three cycles each
      op = OP_BEQ;
      cyc("beq_fetch", V_FR); cyc("beq_dec", V_DEC); cyc("beq_br", V_BR);
      exp_ret = 5; chk_ret("beq");
      op = OP_J;
      cyc("j_fetch", V_FR); cyc("j_dec", V_DEC); cyc("j_jmp", V_JMP);
      exp_ret = 6; chk_ret("j");

      // illegal opcode: one-cycle Illegal_o in DECODE, no retire, back to FETCH
      op = 6'h3F;
      cyc("il_fetch", V_FR); cyc("il_dec", V_DEC_ILL);
      chk_ret("illegal");

      // ten jumps: 16 retires total, 4-bit copy wraps to 0
      for (int k = 0; k < 10; k++) begin
         op = OP_J;
         cyc("wj_fetch", V_FR); cyc("wj_dec", V_DEC); cyc("wj_jmp", V_JMP);
         exp_ret++;
         chk_ret("wrap");
      end
      chk("wrap4_zero", {28'b0, Retired4}, 32'h0);

      // reset asserted in the middle of a stalled MEM_WRITE
      op = OP_SW; mr = 1'b1;
      cyc("rw_fetch", V_FR); cyc("rw_dec", V_DEC); cyc("rw_addr", V_MA);
      mr = 1'b0;
      @(negedge clk);
      chk("rw_memwrite_on", {31'b0, MemWrite}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rw_memwrite_async", {31'b0, MemWrite}, 32'h0);
      chk("rw_ctrl_async", {14'b0, ctrl}, 32'h0);
      exp_ret = 0; chk_ret("rst2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
